// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the seven-segment display blocks: active-low hex glyphs
// {g,f,e,d,c,b,a}, idle pin levels and digit index width.
package seg7_scan_ctrl_pkg;

  localparam int unsigned DIGIT_W = 2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_ctrl_hex.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_7seg
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment controller; digit advance is strobed by
// rising edges of the divided scan_clk, sampled in the clk domain.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_clk,
  input  logic        enable,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [3:0] AN_INV  = SEG_ACTIVE_LOW ? 4'h0 : 4'hF;
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
  localparam logic       DP_INV  = ~SEG_ACTIVE_LOW;

  logic                  scan_q;
  logic                  tick;
  logic                  wrap;
  logic [DIGIT_W-1:0]    digit_sel;
  logic [DIGIT_W-1:0]    next_sel;
  logic [15:0]           shadow_data;
  logic [3:0]            shadow_dp;
  logic [3:0]            shadow_blank;
  logic [15:0]           frame_data;
  logic [3:0]            frame_dp;
  logic [3:0]            frame_blank;
  logic [3:0]            nibble;
  logic [6:0]            seg_pat;
  logic [NUM_DIGITS-1:0] an_onehot;
  logic [3:0]            an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  always_comb begin
    tick     = scan_clk & ~scan_q;
    wrap     = tick && (digit_sel == '1);
    next_sel = digit_sel + 1'b1;
    // Digit 0 of a new frame reads the inputs directly, so it matches the
    // snapshot being written into the shadow on that same edge.
    frame_data  = wrap ? data_in  : shadow_data;
    frame_dp    = wrap ? dp_in    : shadow_dp;
    frame_blank = wrap ? blank_in : shadow_blank;
    nibble      = frame_data[{next_sel, 2'b00} +: 4];
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (nibble),
    .seg    (seg_pat)
  );

  always_comb begin
    an_onehot           = '0;
    an_onehot[next_sel] = 1'b1;
    if (frame_blank[next_sel]) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~an_onehot;
      seg_d = seg_pat;
      dp_d  = ~frame_dp[next_sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q       <= 1'b0;
      digit_sel    <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '1;
      an           <= AN_OFF ^ AN_INV;
      seg          <= SEG_OFF ^ SEG_INV;
      dp           <= 1'b1 ^ DP_INV;
    end else begin
      scan_q <= scan_clk;
      if (tick) begin
        digit_sel <= next_sel;
      end
      if (wrap) begin
        shadow_data  <= data_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
      end
      // Disable darkens immediately; re-enable waits for the next tick.
      if (!enable) begin
        an  <= AN_OFF ^ AN_INV;
        seg <= SEG_OFF ^ SEG_INV;
        dp  <= 1'b1 ^ DP_INV;
      end else if (tick) begin
        an  <= an_d ^ AN_INV;
        seg <= seg_d ^ SEG_INV;
        dp  <= dp_d ^ DP_INV;
      end
    end
  end

endmodule
